// File: rtl/pic_alu_mbseq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pic_alu_mbseq: byte-serial NBYTES-wide sequencer around the 8-bit PIC ALU |
// | Optional: PIC_ALU_MBSEQ_ABORT_EN adds the abort input.  Revision: 1.0     |
// +--------------------------------------------------------------------------+
module pic_alu_mbseq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  input  logic                  cin,
`ifdef PIC_ALU_MBSEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  zero,
  output logic [3:0]            alu_op,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  input  logic [7:0]            alu_res,
  input  logic                  alu_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] c_last_idx = IW'(NBYTES - 1);

  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_sub = 3'd1;
  localparam logic [2:0] c_op_ror = 3'd6;
  localparam logic [2:0] c_op_rol = 3'd7;

  localparam logic [3:0] c_alu_add   = 4'b0000;
  localparam logic [3:0] c_alu_passa = 4'b1101;

  typedef enum logic [1:0] {ST_IDLE, ST_OP, ST_FIX} state_t;

  state_t              r_state;
  logic [8*NBYTES-1:0] r_a;
  logic [8*NBYTES-1:0] r_b;
  logic [8*NBYTES-1:0] r_w;
  logic [2:0]          r_op;
  logic [IW-1:0]       r_idx;
  logic                r_c;
  logic                r_c1;
  logic                r_fin;

  logic [7:0]    w_a_byte;
  logic [7:0]    w_b_byte;
  logic [7:0]    w_w_byte;
  logic          w_last;
  logic          w_is_arith;
  logic          w_is_shift;
  logic          w_is_logic;
  logic [IW-1:0] w_idx_next;

  assign w_a_byte   = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte   = r_b[{r_idx, 3'b000} +: 8];
  assign w_w_byte   = r_w[{r_idx, 3'b000} +: 8];
  assign w_is_arith = (r_op == c_op_add) || (r_op == c_op_sub);
  assign w_is_shift = (r_op == c_op_ror) || (r_op == c_op_rol);
  assign w_is_logic = !w_is_arith && !w_is_shift;
  assign w_last     = (r_op == c_op_ror) ? (r_idx == '0) : (r_idx == c_last_idx);
  assign w_idx_next = (r_op == c_op_ror) ? (r_idx - IW'(1)) : (r_idx + IW'(1));

  // The ALU codes for AND..ROL equal the 3-bit op code zero-extended.
  always_comb begin
    alu_op  = c_alu_passa;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_cin = 1'b0;
    if (r_state == ST_OP && !r_fin) begin
      alu_a = w_a_byte;
      if (w_is_arith) begin
        alu_op = c_alu_add;
        alu_b  = (r_op == c_op_sub) ? ~w_b_byte : w_b_byte;
      end else begin
        alu_op  = {1'b0, r_op};
        alu_b   = w_b_byte;
        alu_cin = w_is_shift ? r_c : 1'b0;
      end
    end else if (r_state == ST_FIX) begin
      alu_op = c_alu_add;
      alu_a  = w_w_byte;
      alu_b  = 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_w     <= '0;
      r_op    <= '0;
      r_idx   <= '0;
      r_c     <= 1'b0;
      r_c1    <= 1'b0;
      r_fin   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
`ifdef PIC_ALU_MBSEQ_ABORT_EN
      if (abort && r_state != ST_IDLE) begin
        r_state <= ST_IDLE;
        r_fin   <= 1'b0;
        busy    <= 1'b0;
      end else
`endif
      begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_a     <= opa;
              r_b     <= opb;
              r_op    <= op;
              r_fin   <= 1'b0;
              busy    <= 1'b1;
              r_state <= ST_OP;
              case (op)
                c_op_ror: begin r_idx <= c_last_idx; r_c <= cin;  end
                c_op_rol: begin r_idx <= '0;         r_c <= cin;  end
                c_op_sub: begin r_idx <= '0;         r_c <= 1'b1; end
                default:  begin r_idx <= '0;         r_c <= 1'b0; end
              endcase
            end
          end
          ST_OP: begin
            if (r_fin) begin
              result  <= r_w;
              cout    <= w_is_logic ? 1'b0 : r_c;
              zero    <= (r_w == '0);
              done    <= 1'b1;
              busy    <= 1'b0;
              r_fin   <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_w[{r_idx, 3'b000} +: 8] <= alu_res;
              if (w_is_arith && r_c) begin
                // Incoming carry pending: take the +1 fix-up pass on this byte.
                r_c1    <= alu_cout;
                r_state <= ST_FIX;
              end else begin
                if (w_is_arith || w_is_shift) r_c <= alu_cout;
                if (w_last) r_fin <= 1'b1;
                else        r_idx <= w_idx_next;
              end
            end
          end
          ST_FIX: begin
            r_w[{r_idx, 3'b000} +: 8] <= alu_res;
            r_c     <= r_c1 | alu_cout;
            r_state <= ST_OP;
            if (w_last) r_fin <= 1'b1;
            else        r_idx <= w_idx_next;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pic_alu_mbseq.sv
`default_nettype none
// Testbench for pic_alu_mbseq: behavioural ALU plus a whole-word reference model.
module tb_pic_alu_mbseq;
  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         cin = 1'b0;
`ifdef PIC_ALU_MBSEQ_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done, cout, zero;
  logic [W-1:0] result;
  logic [3:0]   alu_op;
  logic [7:0]   alu_a, alu_b, alu_res;
  logic         alu_cin, alu_cout;
  logic [8:0]   alu_sum;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] tr_op[$];
  logic [7:0] tr_a[$];

  always #5 clk = ~clk;

  pic_alu_mbseq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
`ifdef PIC_ALU_MBSEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout)
  );

  // 8-bit PIC ALU: ADD ignores carry_in; rotates go through carry.
  always_comb begin
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_res  = alu_a;
    alu_cout = 1'b0;
    case (alu_op)
      4'b0000: begin alu_res = alu_sum[7:0]; alu_cout = alu_sum[8]; end
      4'b0010: alu_res = alu_a & alu_b;
      4'b0011: alu_res = alu_a | alu_b;
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0101: alu_res = ~alu_a;
      4'b0110: begin alu_res = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
      4'b0111: begin alu_res = {alu_a[6:0], alu_cin}; alu_cout = alu_a[7]; end
      default: alu_res = alu_a;
    endcase
  end

  // Whole-word reference; latency counts one fix-up per byte whose incoming carry is 1.
  task automatic model(input logic [2:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, output logic [W-1:0] r, output logic co, output int lat);
    logic [W:0]   s, m, part;
    logic [W-1:0] bp;
    logic         c0;
    int           fixes;
    fixes = 0;
    co    = 1'b0;
    r     = '0;
    case (m_op)
      3'd0, 3'd1: begin
        bp = (m_op == 3'd1) ? ~b : b;
        c0 = (m_op == 3'd1);
        s  = {1'b0, a} + {1'b0, bp} + (W+1)'(c0);
        r  = s[W-1:0];
        co = s[W];
        fixes = int'(c0);
        for (int i = 1; i < NB; i++) begin
          m     = ({{W{1'b0}}, 1'b1} << (8 * i)) - 1'b1;
          part  = ({1'b0, a} & m) + ({1'b0, bp} & m) + (W+1)'(c0);
          fixes = fixes + int'(part[8*i]);
        end
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {ci, a[W-1:1]}; co = a[0]; end
      default: begin r = {a[W-2:0], ci}; co = a[W-1]; end
    endcase
    lat = NB + fixes + 1;
  endtask

  // Issues one operation and waits (bounded) for done; lat = edges from start to done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, output int lat, output bit ok);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; cin = ci;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    tr_op.delete();
    tr_a.delete();
    while (!done && lat < 40) begin
      tr_op.push_back(alu_op);
      tr_a.push_back(alu_a);
      @(negedge clk);
      lat++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_tests++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
    n_tests++; if ({cout, zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {cout, zero}); end
    n_tests++; if ({alu_op, alu_a, alu_b, alu_cin} !== {4'b1101, 17'h0}) begin
      n_fail++; $display("FAIL reset_alu_idle got op=%b a=%h b=%h cin=%b exp op=1101 a=0 b=0 cin=0", alu_op, alu_a, alu_b, alu_cin);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]   ops [6] = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd7, 3'd6};
    logic [W-1:0] as  [6] = '{16'h00FF, 16'h1000, 16'h0001, 16'hA55A, 16'h8001, 16'h0001};
    logic [W-1:0] bs  [6] = '{16'h0001, 16'h0001, 16'h0002, 16'hA55A, 16'h0000, 16'h0000};
    logic         cis [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] ers [6] = '{16'h0100, 16'h0FFF, 16'hFFFF, 16'h0000, 16'h0003, 16'h8000};
    logic         ecs [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int           els [6] = '{4, 4, 4, 3, 3, 3};
    int lat;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      run_op(ops[k], as[k], bs[k], cis[k], lat, ok);
      n_tests++; if (!ok || lat != els[k]) begin n_fail++; $display("FAIL dir%0d_latency got %0d exp %0d", k, lat, els[k]); end
      n_tests++; if (result !== ers[k]) begin n_fail++; $display("FAIL dir%0d_result got %h exp %h", k, result, ers[k]); end
      n_tests++; if (cout !== ecs[k]) begin n_fail++; $display("FAIL dir%0d_cout got %b exp %b", k, cout, ecs[k]); end
      n_tests++; if (zero !== (ers[k] == '0)) begin n_fail++; $display("FAIL dir%0d_zero got %b exp %b", k, zero, (ers[k] == '0)); end
      if (ops[k] == 3'd4) begin
        n_tests++; if (tr_op[0] !== 4'b0100 || tr_op[1] !== 4'b0100) begin
          n_fail++; $display("FAIL xor_alu_op got %b,%b exp 0100,0100", tr_op[0], tr_op[1]);
        end
      end
      if (ops[k] == 3'd6) begin
        n_tests++; if (tr_op[0] !== 4'b0110 || tr_a[0] !== 8'h00 || tr_a[1] !== 8'h01) begin
          n_fail++; $display("FAIL ror_byte_order got op=%b a0=%h a1=%h exp op=0110 a0=00 a1=01", tr_op[0], tr_a[0], tr_a[1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] a, b, er;
    logic         ci, ec;
    int           el, lat;
    bit           ok;
    for (int k = 0; k < 60; k++) begin
      o  = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      if ($urandom_range(0, 3) == 0) b = (o == 3'd1) ? a : ~a;
      if ($urandom_range(0, 5) == 0) a = '1;
      model(o, a, b, ci, er, ec, el);
      run_op(o, a, b, ci, lat, ok);
      n_tests++; if (!ok || lat != el) begin n_fail++; $display("FAIL rnd%0d_latency op=%0d got %0d exp %0d", k, o, lat, el); end
      n_tests++; if (result !== er || cout !== ec || zero !== (er == '0)) begin
        n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h cin=%b got r=%h c=%b z=%b exp r=%h c=%b z=%b",
                           k, o, a, b, ci, result, cout, zero, er, ec, (er == '0));
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, ndone;
    bit ok;
    logic [W-1:0] rdone;
    run_op(3'd0, 16'h0102, 16'h0304, 1'b0, lat, ok);
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 16'h00FF; opb = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; opa = 16'hFFFF; opb = 16'h1234;
    n_tests++; if (result !== 16'h0406) begin n_fail++; $display("FAIL busy_result_hidden got %h exp 0406", result); end
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    rdone = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin ndone++; rdone = result; end
      @(negedge clk);
    end
    n_tests++; if (ndone != 1) begin n_fail++; $display("FAIL busy_start_ignored done_count got %0d exp 1", ndone); end
    n_tests++; if (rdone !== 16'h0100) begin n_fail++; $display("FAIL busy_ignore_result got %h exp 0100", rdone); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle got %b exp 0", busy); end
  endtask

  task automatic test_rst_mid();
    int ndone;
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 16'h00FF; opb = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got busy=%b done=%b exp 0 0", busy, done); end
    n_tests++; if (result !== '0 || cout !== 1'b0 || zero !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_cleared got r=%h c=%b z=%b exp 0", result, cout, zero);
    end
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d exp 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int lat, cyc;
    bit ok;
    run_op(3'd0, 16'h0001, 16'h0001, 1'b0, lat, ok);
    n_tests++; if (!ok || result !== 16'h0002) begin n_fail++; $display("FAIL b2b_first got %h exp 0002", result); end
    start = 1'b1; op = 3'd1; opa = 16'h0005; opb = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_accepted got busy=%b done=%b exp 1 0", busy, done); end
    cyc = 0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    n_tests++; if (!done || result !== 16'h0002 || cout !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got done=%b r=%h c=%b exp 1 0002 1", done, result, cout);
    end
  endtask

`ifdef PIC_ALU_MBSEQ_ABORT_EN
  task automatic test_abort();
    int lat, ndone;
    bit ok;
    run_op(3'd0, 16'h1200, 16'h0034, 1'b0, lat, ok);
    n_tests++; if (!ok || result !== 16'h1234) begin n_fail++; $display("FAIL abort_prior got %h exp 1234", result); end
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 16'h00FF; opb = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy=%b done=%b exp 0 0", busy, done); end
    n_tests++; if (result !== 16'h1234) begin n_fail++; $display("FAIL abort_result_kept got %h exp 1234", result); end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_rst_mid();
    test_back_to_back();
`ifdef PIC_ALU_MBSEQ_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
